// File: rtl/data_splice_param.sv
// rtl/data_splice_param.sv - packs SOP/EOP byte beats into 134-bit flagged packet words
// Handles truncation at MAX_LEN, abort on a mid-packet SOP, and keeps statistics counters.
module data_splice_param #(
  parameter int IN_BYTES = 1,
  parameter int MAX_LEN  = 2048,
  parameter int CNT_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_data_wr,
  input  logic [IN_BYTES*8+1:0] iv_data,
  input  logic [3:0]            iv_last_vld,
  output logic                  o_pkt_wr,
  output logic [133:0]          ov_pkt,
  output logic [1:0]            ov_state,
  output logic                  o_trunc,
  output logic                  o_abort,
  output logic [CNT_W-1:0]      ov_pkt_cnt,
  output logic [CNT_W-1:0]      ov_trunc_cnt,
  output logic [CNT_W-1:0]      ov_abort_cnt
);

  localparam int BW = IN_BYTES * 8;
  // One spare bit lets len overshoot MAX_LEN by a word without wrapping.
  localparam int LW = $clog2(MAX_LEN + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TRAN = 2'b10,
    S_DISC = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       acc_q, acc_d;
  logic [4:0]         byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]      len_q, len_d;
  logic               head_q, head_d;
  logic               pkt_wr_q, pkt_wr_d;
  logic [133:0]       pkt_q, pkt_d;
  logic               trunc_q, trunc_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   trunc_cnt_q, trunc_cnt_d;
  logic [CNT_W-1:0]   abort_cnt_q, abort_cnt_d;

  logic               sop, eop;
  logic [BW-1:0]      beat;
  logic [4:0]         lv_c, nvalid;

  assign sop    = iv_data[BW+1];
  assign eop    = iv_data[BW];
  assign beat   = iv_data[BW-1:0];
  assign lv_c   = ({1'b0, iv_last_vld} > 5'(IN_BYTES - 1)) ? 5'(IN_BYTES - 1) : {1'b0, iv_last_vld};
  assign nvalid = eop ? (lv_c + 5'd1) : 5'(IN_BYTES);

  logic               start, accept, head_cur;
  logic [4:0]         off, fill, inv;
  logic [LW-1:0]      len_new;
  logic [127:0]       word, beat_pos, keep_mask;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    head_d      = head_q;
    pkt_wr_d    = 1'b0;
    pkt_d       = pkt_q;
    trunc_d     = 1'b0;
    abort_d     = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    abort_cnt_d = abort_cnt_q;
    start       = 1'b0;
    accept      = 1'b0;

    if (i_data_wr) begin
      unique case (state_q)
        S_IDLE: start = sop;
        S_TRAN: begin
          if (sop) begin
            start       = 1'b1;
            abort_d     = 1'b1;
            abort_cnt_d = abort_cnt_q + CNT_W'(1);
          end else begin
            accept = 1'b1;
          end
        end
        S_DISC: begin
          if (sop)      start   = 1'b1;
          else if (eop) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A starting beat ignores whatever partial word is held.
    off       = start ? 5'd0 : byte_cnt_q;
    head_cur  = start ? 1'b1 : head_q;
    len_new   = (start ? '0 : len_q) + LW'(IN_BYTES);
    fill      = off + nvalid;
    inv       = 5'd16 - fill;
    beat_pos  = (128'(beat) << (128 - BW)) >> {off, 3'b000};
    keep_mask = ~({128{1'b1}} >> {fill, 3'b000});
    word      = (start ? 128'd0 : acc_q) | (beat_pos & keep_mask);

    if (start || accept) begin
      if (eop) begin
        pkt_wr_d   = 1'b1;
        pkt_d      = {head_cur ? 2'b00 : 2'b10, inv[3:0], word};
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
        state_d    = S_IDLE;
        acc_d      = '0;
        byte_cnt_d = '0;
        len_d      = '0;
        head_d     = 1'b0;
      end else if (fill == 5'd16) begin
        pkt_wr_d   = 1'b1;
        acc_d      = '0;
        byte_cnt_d = '0;
        if (accept && (len_new >= LW'(MAX_LEN))) begin
          pkt_d       = {head_cur ? 2'b00 : 2'b10, 4'd0, word};
          pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
          trunc_d     = 1'b1;
          trunc_cnt_d = trunc_cnt_q + CNT_W'(1);
          state_d     = S_DISC;
          len_d       = '0;
          head_d      = 1'b0;
        end else begin
          pkt_d   = {head_cur ? 2'b01 : 2'b11, 4'd0, word};
          state_d = S_TRAN;
          len_d   = len_new;
          head_d  = 1'b0;
        end
      end else begin
        acc_d      = word;
        byte_cnt_d = fill;
        len_d      = len_new;
        head_d     = head_cur;
        state_d    = S_TRAN;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      head_q      <= 1'b0;
      pkt_wr_q    <= 1'b0;
      pkt_q       <= '0;
      trunc_q     <= 1'b0;
      abort_q     <= 1'b0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      head_q      <= head_d;
      pkt_wr_q    <= pkt_wr_d;
      pkt_q       <= pkt_d;
      trunc_q     <= trunc_d;
      abort_q     <= abort_d;
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign o_pkt_wr     = pkt_wr_q;
  assign ov_pkt       = pkt_q;
  assign ov_state     = state_q;
  assign o_trunc      = trunc_q;
  assign o_abort      = abort_q;
  assign ov_pkt_cnt   = pkt_cnt_q;
  assign ov_trunc_cnt = trunc_cnt_q;
  assign ov_abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_data_splice_param.sv
// tb/tb_data_splice_param.sv - directed bench for data_splice_param
// Three instances: 1-byte beats, 4-byte beats, and 1-byte beats with MAX_LEN=32.
module tb_data_splice_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         wr1 = 0, wr4 = 0, wrt = 0;
  logic [9:0]   d1 = '0, dt = '0;
  logic [33:0]  d4 = '0;
  logic [3:0]   lv1 = '0, lv4 = '0, lvt = '0;

  logic         pw1, pw4, pwt, tr1, tr4, trt, ab1, ab4, abt;
  logic [133:0] pk1, pk4, pkt_t;
  logic [1:0]   st1, st4, stt;
  logic [15:0]  pc1, tc1, ac1, pc4, tc4, ac4, pct, tct, act;

  data_splice_param #(.IN_BYTES(1), .MAX_LEN(2048), .CNT_W(16)) u1 (
    .i_clk(clk), .i_rst(rst), .i_data_wr(wr1), .iv_data(d1), .iv_last_vld(lv1),
    .o_pkt_wr(pw1), .ov_pkt(pk1), .ov_state(st1), .o_trunc(tr1), .o_abort(ab1),
    .ov_pkt_cnt(pc1), .ov_trunc_cnt(tc1), .ov_abort_cnt(ac1));

  data_splice_param #(.IN_BYTES(4), .MAX_LEN(2048), .CNT_W(16)) u4 (
    .i_clk(clk), .i_rst(rst), .i_data_wr(wr4), .iv_data(d4), .iv_last_vld(lv4),
    .o_pkt_wr(pw4), .ov_pkt(pk4), .ov_state(st4), .o_trunc(tr4), .o_abort(ab4),
    .ov_pkt_cnt(pc4), .ov_trunc_cnt(tc4), .ov_abort_cnt(ac4));

  data_splice_param #(.IN_BYTES(1), .MAX_LEN(32), .CNT_W(16)) ut (
    .i_clk(clk), .i_rst(rst), .i_data_wr(wrt), .iv_data(dt), .iv_last_vld(lvt),
    .o_pkt_wr(pwt), .ov_pkt(pkt_t), .ov_state(stt), .o_trunc(trt), .o_abort(abt),
    .ov_pkt_cnt(pct), .ov_trunc_cnt(tct), .ov_abort_cnt(act));

  logic [133:0] q1[$], q4[$], qt[$];
  int n_abort1 = 0, n_trunct = 0;
  int checks = 0, errors = 0;

  always @(negedge clk) begin
    if (pw1) q1.push_back(pk1);
    if (pw4) q4.push_back(pk4);
    if (pwt) qt.push_back(pkt_t);
    if (ab1) n_abort1++;
    if (trt) n_trunct++;
  end

  function automatic logic [133:0] mkw(input logic [1:0] f, input logic [3:0] inv,
                                       input int st, input int n);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) d = {d[119:0], (i < n) ? 8'(st + i) : 8'h00};
    return {f, inv, d};
  endfunction

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int inst, input bit sop, input bit eop,
                      input logic [31:0] data, input logic [3:0] lv);
    case (inst)
      0: begin wr1 = 1; d1 = {sop, eop, data[7:0]}; lv1 = lv; end
      1: begin wr4 = 1; d4 = {sop, eop, data};      lv4 = lv; end
      default: begin wrt = 1; dt = {sop, eop, data[7:0]}; lvt = lv; end
    endcase
    @(negedge clk);
    wr1 = 0; wr4 = 0; wrt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input int inst, input int start, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send(inst, i == 0, i == n - 1, 32'(start + i), 4'd0);
      if (i < n - 1) idle(gap);
    end
  endtask

  task automatic expect_word(input int inst, input logic [133:0] exp, input string tag);
    logic [133:0] obs;
    obs = 'x;
    case (inst)
      0: if (q1.size() > 0) obs = q1.pop_front();
      1: if (q4.size() > 0) obs = q4.pop_front();
      default: if (qt.size() > 0) obs = qt.pop_front();
    endcase
    chk(tag, obs, exp);
  endtask

  task automatic expect_none(input int inst, input string tag);
    int sz;
    case (inst)
      0: sz = q1.size();
      1: sz = q4.size();
      default: sz = qt.size();
    endcase
    chk(tag, 134'(sz), 134'd0);
  endtask

  initial begin
    #2 rst = 1;
    idle(2);
    chk("rst_state", 134'(st1), 134'd0);
    chk("rst_pkt_wr", 134'(pw1), 134'd0);
    chk("rst_pkt", pk1, 134'd0);
    chk("rst_pkt_cnt", 134'(pc1), 134'd0);
    chk("rst_abort_cnt", 134'(ac1), 134'd0);
    rst = 0;
    idle(1);

    // 40-byte packet on 1-byte beats
    send_pkt(0, 8'h00, 40, 0);
    idle(3);
    expect_word(0, mkw(2'b01, 4'd0, 8'h00, 16), "p40_w0");
    expect_word(0, mkw(2'b11, 4'd0, 8'h10, 16), "p40_w1");
    expect_word(0, mkw(2'b10, 4'd8, 8'h20, 8),  "p40_w2");
    expect_none(0, "p40_extra");
    chk("p40_pkt_cnt", 134'(pc1), 134'd1);
    chk("p40_state", 134'(st1), 134'd0);

    // beat without sop in idle is dropped
    send(0, 0, 1, 32'h55, 4'd0);
    idle(3);
    expect_none(0, "stray");

    // sop arriving at byte 5 aborts the partial word
    for (int i = 0; i < 5; i++) send(0, i == 0, 0, 32'(8'hA0 + i), 4'd0);
    send_pkt(0, 8'hB0, 4, 0);
    idle(3);
    expect_word(0, mkw(2'b00, 4'd12, 8'hB0, 4), "abort_new");
    expect_none(0, "abort_extra");
    chk("abort_pulses", 134'(n_abort1), 134'd1);
    chk("abort_cnt", 134'(ac1), 134'd1);
    chk("abort_pkt_cnt", 134'(pc1), 134'd2);

    // 20-byte packet without and with 3-cycle gaps
    send_pkt(0, 8'h40, 20, 0);
    send_pkt(0, 8'h40, 20, 3);
    idle(3);
    expect_word(0, mkw(2'b01, 4'd0,  8'h40, 16), "nogap_w0");
    expect_word(0, mkw(2'b10, 4'd12, 8'h50, 4),  "nogap_w1");
    expect_word(0, mkw(2'b01, 4'd0,  8'h40, 16), "gap_w0");
    expect_word(0, mkw(2'b10, 4'd12, 8'h50, 4),  "gap_w1");
    expect_none(0, "gap_extra");
    chk("gap_pkt_cnt", 134'(pc1), 134'd4);

    // 4-byte beats: 10-byte packet, junk past last_vld must be zeroed
    send(1, 1, 0, 32'h11121314, 4'd0);
    send(1, 0, 0, 32'h15161718, 4'd0);
    send(1, 0, 1, 32'h191AEEEE, 4'd1);
    idle(3);
    expect_word(1, mkw(2'b00, 4'd6, 8'h11, 10), "w4_p10");
    // last_vld above IN_BYTES-1 clamps to a full beat
    send(1, 1, 1, 32'h21222324, 4'd9);
    idle(3);
    expect_word(1, mkw(2'b00, 4'd12, 8'h21, 4), "w4_clamp");
    expect_none(1, "w4_extra");
    chk("w4_pkt_cnt", 134'(pc4), 134'd2);

    // MAX_LEN=32: 50-byte packet is truncated, rest discarded
    for (int i = 0; i < 40; i++) send(2, i == 0, 0, 32'(i), 4'd0);
    chk("trunc_state_disc", 134'(stt), 134'd3);
    for (int i = 40; i < 50; i++) send(2, 0, i == 49, 32'(i), 4'd0);
    idle(3);
    chk("trunc_state_idle", 134'(stt), 134'd0);
    expect_word(2, mkw(2'b01, 4'd0, 8'h00, 16), "trunc_w0");
    expect_word(2, mkw(2'b10, 4'd0, 8'h10, 16), "trunc_w1");
    expect_none(2, "trunc_extra");
    chk("trunc_pulses", 134'(n_trunct), 134'd1);
    chk("trunc_cnt", 134'(tct), 134'd1);
    chk("trunc_pkt_cnt", 134'(pct), 134'd1);
    send_pkt(2, 8'h60, 3, 0);
    idle(3);
    expect_word(2, mkw(2'b00, 4'd13, 8'h60, 3), "after_trunc");
    // eop exactly at MAX_LEN is a normal tail
    send_pkt(2, 8'h70, 32, 0);
    idle(3);
    expect_word(2, mkw(2'b01, 4'd0, 8'h70, 16), "max_w0");
    expect_word(2, mkw(2'b10, 4'd0, 8'h80, 16), "max_w1");
    expect_none(2, "max_extra");
    chk("max_trunc_cnt", 134'(tct), 134'd1);
    chk("max_pkt_cnt", 134'(pct), 134'd3);

    // reset in the middle of a word
    for (int i = 0; i < 5; i++) send(0, i == 0, 0, 32'(8'hC0 + i), 4'd0);
    #2 rst = 1;
    #1;
    chk("mid_rst_state", 134'(st1), 134'd0);
    chk("mid_rst_pkt", pk1, 134'd0);
    chk("mid_rst_pkt_cnt", 134'(pc1), 134'd0);
    chk("mid_rst_abort_cnt", 134'(ac1), 134'd0);
    @(negedge clk);
    rst = 0;
    idle(1);
    send_pkt(0, 8'hD0, 16, 0);
    idle(3);
    expect_word(0, mkw(2'b00, 4'd0, 8'hD0, 16), "post_rst_w");
    expect_none(0, "post_rst_extra");
    chk("post_rst_pkt_cnt", 134'(pc1), 134'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
